// File: rtl/matmul_row_sequencer_if.sv
// matmul_row_sequencer_if
//   Bundle between the row sequencer and the int8 matrix-multiply datapath.
//   master (sequencer): drives the latched operands, the row index and the
//                       one-cycle issue strobe; receives the row result.
//   slave  (datapath) : the mirror image.
//   Signals:
//     matriz_a / matriz_b  latched operands, element (r,c) at [8*(c+SIZE*r) +: 8]
//     row                  row index being issued
//     row_valid            issue strobe, one cycle per row
//     row_result           one int8 per column for the issued row
interface matmul_row_sequencer_if #(
    parameter int SIZE = 5
) ();
    logic [8*SIZE*SIZE-1:0] matriz_a;
    logic [8*SIZE*SIZE-1:0] matriz_b;
    logic [7:0]             row;
    logic                   row_valid;
    logic [8*SIZE-1:0]      row_result;

    modport master (
        output matriz_a, matriz_b, row, row_valid,
        input  row_result
    );

    modport slave (
        input  matriz_a, matriz_b, row, row_valid,
        output row_result
    );
endinterface

// File: rtl/matmul_row_sequencer.sv
// matmul_row_sequencer
//   Sequences a row-at-a-time signed int8 matrix multiply over SIZE x SIZE
//   operands. A job is accepted on start (in IDLE or DONE), the operands are
//   latched and presented to the datapath, rows 0..SIZE-1 are issued one at a
//   time, each row result is captured ROW_LAT cycles after its issue cycle,
//   and a one-cycle done pulse closes the job. No arithmetic happens here.
//
//   Ports:
//     clock, reset_n   rising-edge clock, asynchronous active-low reset
//     start            job request, honoured only when not busy
//     op_a, op_b       operands, element (r,c) at [8*(c+SIZE*r) +: 8]
//     busy             job in progress (ISSUE/WAIT/CAPTURE)
//     done             one-cycle completion pulse
//     result           product matrix, row r at [8*SIZE*r +: 8*SIZE]
//     dp               datapath bundle (master side)
//     abort, aborted   only with MATMUL_SEQ_ABORT_EN: abort a running job,
//                      aborted pulses for one cycle afterwards
//
//   Optional build macro: MATMUL_SEQ_ABORT_EN
//
//   State   | meaning
//   IDLE    | waiting for start
//   ISSUE   | present row index with a one-cycle strobe, arm the wait counter
//   WAIT    | count down datapath latency, capture the row at zero
//   CAPTURE | advance to the next row or finish
//   DONE    | one-cycle completion pulse, may accept a new job
module matmul_row_sequencer #(
    parameter int SIZE    = 5,
    parameter int ROW_LAT = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [8*SIZE*SIZE-1:0]  op_a,
    input  logic [8*SIZE*SIZE-1:0]  op_b,
`ifdef MATMUL_SEQ_ABORT_EN
    input  logic                    abort,
    output logic                    aborted,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [8*SIZE*SIZE-1:0]  result,
    matmul_row_sequencer_if.master  dp
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [3:0] LAST_ROW = 4'(SIZE - 1);
    localparam logic [1:0] WAIT_INIT = 2'(ROW_LAT - 1);

    logic [2:0]             state;
    logic [3:0]             row;
    logic [1:0]             wait_cnt;
    logic [8*SIZE*SIZE-1:0] mat_a;
    logic [8*SIZE*SIZE-1:0] mat_b;

    assign busy         = (state == ISSUE) || (state == WAIT) || (state == CAPTURE);
    assign done         = (state == DONE);
    assign dp.row_valid = (state == ISSUE);
    assign dp.row       = {4'b0000, row};
    assign dp.matriz_a  = mat_a;
    assign dp.matriz_b  = mat_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            row      <= '0;
            wait_cnt <= '0;
            result   <= '0;
            mat_a    <= '0;
            mat_b    <= '0;
`ifdef MATMUL_SEQ_ABORT_EN
            aborted  <= 1'b0;
`endif
        end else begin
`ifdef MATMUL_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mat_a  <= op_a;
                        mat_b  <= op_b;
                        result <= '0;
                        row    <= '0;
                        state  <= ISSUE;
                    end else begin
                        state  <= IDLE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt != 2'd0) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end else begin
                        result[8*SIZE*int'(row) +: 8*SIZE] <= dp.row_result;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (row == LAST_ROW) begin
                        state <= DONE;
                    end else begin
                        row   <= row + 4'd1;
                        state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef MATMUL_SEQ_ABORT_EN
            // Overrides whatever the running job would have done this edge.
            if (abort && busy) begin
                state   <= IDLE;
                result  <= '0;
                aborted <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_matmul_row_sequencer.sv
// Directed bench for matmul_row_sequencer: one instance with ROW_LAT=1 and
// one with ROW_LAT=3, each driven by a small behavioural datapath that
// presents the product row only in the cycle the sequencer should sample it.
module tb_matmul_row_sequencer;
    localparam int S = 5;
    localparam int W = 8*S*S;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset_n;
    logic         start1, start3;
    logic [W-1:0] op_a1, op_b1, op_a3, op_b3;
    logic         busy1, done1, busy3, done3;
    logic [W-1:0] res1, res3;
`ifdef MATMUL_SEQ_ABORT_EN
    logic         abort1, aborted1, abort3, aborted3;
`endif

    matmul_row_sequencer_if #(.SIZE(S)) if1 ();
    matmul_row_sequencer_if #(.SIZE(S)) if3 ();

    matmul_row_sequencer #(.SIZE(S), .ROW_LAT(1)) u1 (
        .clock(clock), .reset_n(reset_n), .start(start1),
        .op_a(op_a1), .op_b(op_b1),
`ifdef MATMUL_SEQ_ABORT_EN
        .abort(abort1), .aborted(aborted1),
`endif
        .busy(busy1), .done(done1), .result(res1), .dp(if1)
    );

    matmul_row_sequencer #(.SIZE(S), .ROW_LAT(3)) u3 (
        .clock(clock), .reset_n(reset_n), .start(start3),
        .op_a(op_a3), .op_b(op_b3),
`ifdef MATMUL_SEQ_ABORT_EN
        .abort(abort3), .aborted(aborted3),
`endif
        .busy(busy3), .done(done3), .result(res3), .dp(if3)
    );

    // ---------------- datapath models ----------------
    function automatic logic [8*S-1:0] row_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic [7:0] r);
        logic [8*S-1:0] o;
        logic [7:0] acc, x, y;
        o = '0;
        for (int c = 0; c < S; c++) begin
            acc = 8'h00;
            for (int k = 0; k < S; k++) begin
                x   = a[8*(k+S*int'(r)) +: 8];
                y   = b[8*(c+S*k) +: 8];
                acc = acc + x*y;
            end
            o[8*c +: 8] = acc;
        end
        return o;
    endfunction

    logic [8*S-1:0] p1;
    logic [8*S-1:0] p3 [4];
    bit             extra3 = 1'b0;

    always @(posedge clock) begin
        p1    <= if1.row_valid ? row_prod(if1.matriz_a, if1.matriz_b, if1.row) : '0;
        p3[0] <= if3.row_valid ? row_prod(if3.matriz_a, if3.matriz_b, if3.row) : '0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        p3[3] <= p3[2];
    end
    assign if1.row_result = p1;
    assign if3.row_result = extra3 ? p3[3] : p3[2];

    // ---------------- strobe monitor ----------------
    bit edge_log = 1'b0;
    int edge_cnt = 0;
    int strobe_row[$];
    int strobe_t[$];
    always @(posedge clock) begin
        edge_cnt <= edge_cnt + 1;
        if (edge_log && if1.row_valid === 1'b1) begin
            strobe_row.push_back(int'(if1.row));
            strobe_t.push_back(edge_cnt);
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one job; cyc ends as the cycle number (start edge = cycle 0) in
    // which done is seen. peek_res is the result seen in cycle 'peek'.
    task automatic job(input int u, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit pulse, input int peek,
                       output int cyc, output logic [W-1:0] peek_res);
        @(negedge clock);
        if (u == 1) begin op_a1 = a; op_b1 = b; start1 = 1'b1; end
        else        begin op_a3 = a; op_b3 = b; start3 = 1'b1; end
        @(posedge clock); #1;
        start1 = 1'b0; start3 = 1'b0;
        cyc = 1;
        peek_res = 'x;
        while (((u == 1) ? done1 : done3) !== 1'b1 && cyc < 100) begin
            if (cyc == peek) peek_res = (u == 1) ? res1 : res3;
            if (u == 1 && pulse) start1 = (cyc == 4 || cyc == 9);
            @(posedge clock); #1;
            cyc++;
        end
        start1 = 1'b0;
    endtask

    logic [W-1:0] mat_i, mat_2i, mat_b, exp_2b, peek_v;
    int cyc;

    initial begin
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) begin
                mat_i [8*(c+S*r) +: 8] = (r == c) ? 8'd1 : 8'd0;
                mat_2i[8*(c+S*r) +: 8] = (r == c) ? 8'd2 : 8'd0;
                mat_b [8*(c+S*r) +: 8] = 8'(r*S + c);
                exp_2b[8*(c+S*r) +: 8] = 8'(2*(r*S + c));
            end

        reset_n = 1'b0;
        start1 = 1'b0; start3 = 1'b0;
        op_a1 = '0; op_b1 = '0; op_a3 = '0; op_b3 = '0;
`ifdef MATMUL_SEQ_ABORT_EN
        abort1 = 1'b0; abort3 = 1'b0;
`endif
        #12;
        chk("rst_busy",  busy1, 0);
        chk("rst_done",  done1, 0);
        chk("rst_res",   res1, 0);
        chk("rst_valid", if1.row_valid, 0);
        chk("rst_row",   if1.row, 0);
        chk("rst_mat_a", if1.matriz_a, 0);
        @(negedge clock); reset_n = 1'b1;

        // identity x B = B, strobes rows 0..4 three cycles apart
        edge_log = 1'b1;
        job(1, mat_i, mat_b, 1'b0, 0, cyc, peek_v);
        edge_log = 1'b0;
        chk("id_latency", cyc, 16);
        chk("id_result", res1, mat_b);
        chk("id_busy_in_done", busy1, 0);
        chk("id_mat_a", if1.matriz_a, mat_i);
        chk("strobe_n", strobe_row.size(), 5);
        for (int i = 0; i < strobe_row.size() && i < 5; i++) begin
            chk("strobe_row", strobe_row[i], i);
            if (i > 0) chk("strobe_gap", strobe_t[i] - strobe_t[i-1], 3);
        end
        @(posedge clock); #1;
        chk("done_one_cycle", done1, 0);
        chk("idle_busy", busy1, 0);
        chk("held_result", res1, mat_b);

        // ones x (-1): every element -5; stray start pulses while busy
        job(1, {25{8'h01}}, {25{8'hFF}}, 1'b1, 4, cyc, peek_v);
        chk("neg_latency", cyc, 16);
        chk("neg_result", res1, {25{8'hFB}});
        chk("partial_rows", peek_v, {160'd0, {5{8'hFB}}});

        // 16*16*5 wraps to zero
        job(1, {25{8'h10}}, {25{8'h10}}, 1'b0, 0, cyc, peek_v);
        chk("wrap_latency", cyc, 16);
        chk("wrap_result", res1, 0);

        // start held high: back-to-back jobs, op_a changed mid-job
        @(negedge clock);
        op_a1 = mat_i; op_b1 = mat_b; start1 = 1'b1;
        @(posedge clock); #1;
        cyc = 1;
        while (done1 !== 1'b1 && cyc < 100) begin
            if (cyc == 5) op_a1 = '0;
            @(posedge clock); #1;
            cyc++;
        end
        chk("b2b_first_latency", cyc, 16);
        chk("b2b_first_result", res1, mat_b);
        cyc = 0;
        do begin
            @(posedge clock); #1;
            cyc++;
        end while (done1 !== 1'b1 && cyc < 100);
        start1 = 1'b0;
        chk("b2b_period", cyc, 16);
        chk("b2b_second_result", res1, 0);
        @(posedge clock); #1;
        chk("b2b_stop_done", done1, 0);
        chk("b2b_stop_busy", busy1, 0);

        // ROW_LAT=3 with matching datapath delay
        job(3, mat_2i, mat_b, 1'b0, 0, cyc, peek_v);
        chk("lat3_latency", cyc, 26);
        chk("lat3_result", res3, exp_2b);

        // datapath one cycle late: the sampling point misses every row
        extra3 = 1'b1;
        job(3, mat_2i, mat_b, 1'b0, 0, cyc, peek_v);
        chk("late_latency", cyc, 26);
        chk("late_mismatch", res3 !== exp_2b, 1);
        chk("late_result", res3, 0);
        extra3 = 1'b0;

        // reset during WAIT of row 2 (ROW_LAT=3: row 2 issued in cycle 11)
        @(negedge clock);
        op_a3 = mat_2i; op_b3 = mat_b; start3 = 1'b1;
        @(posedge clock); #1;
        start3 = 1'b0;
        for (int i = 1; i < 13; i++) begin @(posedge clock); #1; end
        chk("pre_rst_row", if3.row, 2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy3, 0);
        chk("mid_rst_done", done3, 0);
        chk("mid_rst_res", res3, 0);
        chk("mid_rst_mat_a", if3.matriz_a, 0);
        chk("mid_rst_row", if3.row, 0);
        @(negedge clock); reset_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            if (done3 === 1'b1 || busy3 === 1'b1) cyc++;
        end
        chk("post_rst_quiet", cyc, 0);
        chk("post_rst_res", res3, 0);

`ifdef MATMUL_SEQ_ABORT_EN
        // abort during WAIT of row 3 (ROW_LAT=1: row 3 WAIT in cycle 11)
        @(negedge clock);
        op_a1 = mat_i; op_b1 = mat_b; start1 = 1'b1;
        @(posedge clock); #1;
        start1 = 1'b0;
        for (int i = 1; i < 11; i++) begin @(posedge clock); #1; end
        chk("abort_at_row", if1.row, 3);
        chk("abort_res_before", res1 !== 0, 1);
        abort1 = 1'b1;
        @(posedge clock); #1;
        abort1 = 1'b0;
        chk("aborted_pulse", aborted1, 1);
        chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0);
        chk("abort_res", res1, 0);
        @(posedge clock); #1;
        chk("aborted_clear", aborted1, 0);
        chk("abort_no_done", done1, 0);
        job(1, mat_i, mat_b, 1'b0, 0, cyc, peek_v);
        chk("after_abort_latency", cyc, 16);
        chk("after_abort_result", res1, mat_b);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/matmul_row_sequencer.md
Name: matmul_row_sequencer

Overview:
- Controller that sequences a row-at-a-time signed int8 matrix-multiply datapath over SIZE×SIZE operands.
- Accepts a job via start, latches both operands, and drives them to the datapath.
- Issues row indices 0..SIZE-1, waits the datapath latency for each row, and assembles the result matrix.
- Signals completion with a done pulse. Sits between the host/bus interface and the multiply datapath.

Parameters:
- SIZE, 5, matrix dimension (2..16).
- ROW_LAT, 1, cycles from dp_row_valid to dp_row_result being valid (1..4).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE or DONE.
- op_a  in  8*SIZE*SIZE  operand A, signed int8, element (r,c) at bits [8*(c+SIZE*r) +: 8].
- op_b  in  8*SIZE*SIZE  operand B, same packing.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- result  out  8*SIZE*SIZE  product matrix, same packing; row r at [8*SIZE*r +: 8*SIZE].
- dp_matriz_a  out  8*SIZE*SIZE  latched A to datapath.
- dp_matriz_b  out  8*SIZE*SIZE  latched B to datapath.
- dp_row  out  8  row index being issued.
- dp_row_valid  out  1  one-cycle issue strobe.
- dp_row_result  in  8*SIZE  datapath row output, int8 per column, wrap-around arithmetic (no saturation).

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0, done=0, dp_row_valid=0, dp_row=0, result=0, dp_matriz_a=0, dp_matriz_b=0, row counter=0, wait counter=0. Reset mid-job discards the job; no done is issued.
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE/DONE + start=1:
  - Latch op_a/op_b into dp_matriz_a/dp_matriz_b.
  - Clear result to 0, row=0, go to ISSUE; busy=1 from the next cycle.
  - start while busy=1 is ignored (no queueing).
- ISSUE (1 cycle): dp_row=row, dp_row_valid=1; load wait counter with ROW_LAT-1; go to WAIT.
- WAIT: dp_row_valid=0, dp_row holds its value. While counter>0, decrement. At counter=0, sample dp_row_result into result row `row` on that edge and go to CAPTURE.
  - Effective timing: dp_row_result is sampled ROW_LAT cycles after the ISSUE cycle.
- CAPTURE (1 cycle, bookkeeping):
  - row==SIZE-1: go to DONE.
  - Otherwise: row+=1, go to ISSUE.
  - row never wraps past SIZE-1.
- DONE: done=1 for exactly one cycle and busy=0 in that cycle; then IDLE unless start=1 in that cycle, which begins a new job (back-to-back allowed).
- Per-row cost: ROW_LAT+2 cycles.
- Latency: start accepted at edge k → done high in cycle k+1+SIZE*(ROW_LAT+2).
  - SIZE=5, ROW_LAT=1: done at k+16.
- Result rows not yet captured read 0 while busy. The full result is held stable from DONE until the next accepted start.
- dp_matriz_a/b are stable for the entire job; op_a/op_b changes during busy have no effect.
- No arithmetic in this block; width of dp_row_result is taken verbatim.

Optional Feature:
- Macro MATMUL_SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit) and output port aborted (1 bit, reset 0).
  - abort=1 sampled in ISSUE/WAIT/CAPTURE → next state IDLE, result cleared to 0, busy=0, aborted=1 for one cycle, no done.
  - abort in IDLE/DONE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Undefined: ports absent; jobs always run to completion.

Test Plan:
- Reset/idle: reset_n=0 mid-WAIT of row 2 → all outputs 0 immediately, and after release busy=0, done=0, result=0.
- Identity job: SIZE=5, ROW_LAT=1, A=I, B with element (r,c)=r*5+c; model datapath returns row r of A×B.
  - done at start-edge+16; result==B.
  - dp_row sequence 0,1,2,3,4, each strobe 1 cycle, strobes 3 cycles apart.
- Wrap arithmetic: A all 16, B all 16 → every result element 0x00 (5*256 mod 256), with no flags.
- Latency sweep: ROW_LAT=3 with a model datapath of matching delay → done at start+26; a datapath delayed 1 cycle extra produces mismatched rows (checks the sampling point).
- Handshake: start held high continuously.
  - A second job begins in the DONE cycle; done pulses every 16 cycles.
  - start pulses during busy are ignored; op_a changed mid-job does not alter the result.
- MATMUL_SEQ_ABORT_EN: abort=1 during row 3 WAIT → aborted pulse next cycle, busy=0, result=0, no done; a subsequent start completes normally.
